// File: rtl/sp_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sp_ram_fifo_pkg
// Purpose : Shared types and default sizing for the single-port-RAM FIFO
//           controller and its pointer sub-module.
// Contents: op_t            - last RAM operation granted (read or write)
//           c_default_width - default data word width
//           c_default_depth - default RAM depth in words
// Revision: 1.0 - initial release
// ============================================================================
package sp_ram_fifo_pkg;

   localparam int c_default_width = 8;
   localparam int c_default_depth = 64;

   typedef enum logic [0:0] {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage : sp_ram_fifo_pkg
`default_nettype wire

// File: rtl/sp_ram_fifo_ctrl_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ptr
// Purpose : ADDR_BUS-bit RAM pointer that advances by one when inc is high
//           and wraps from DEPTH-1 back to 0 by natural overflow.
// Ports   : clk  - clock
//           rst  - asynchronous active-low reset (pointer returns to 0)
//           inc  - advance the pointer at the next clock edge
//           ptr  - current pointer value
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ptr #(
   parameter int ADDR_BUS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   output logic [ADDR_BUS-1:0] ptr
);

   logic [ADDR_BUS-1:0] ptr_q;
   logic [ADDR_BUS-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/sp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sp_ram_fifo_ctrl
// Purpose : Turns an asynchronous-read single-port RAM into a DEPTH-word FIFO
//           with a one-entry output register. Reads and writes share the one
//           RAM port through an alternating-priority arbiter.
// Ports   : clk, rst                   - clock, async active-low reset
//           wr_valid/wr_ready/wr_data  - producer handshake
//           rd_valid/rd_ready/rd_data  - consumer handshake (registered data)
//           ram_we/ram_addr/ram_din    - RAM write enable, address, write data
//           ram_dout                   - combinational RAM read data
//           full                       - RAM holds DEPTH words
//           fill                       - words in RAM (output register excluded)
// Revision: 1.0 - initial release
// ============================================================================
module sp_ram_fifo_ctrl
   import sp_ram_fifo_pkg::*;
#(
   parameter int WIDTH    = c_default_width,
   parameter int DEPTH    = c_default_depth,
   parameter int ADDR_BUS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [WIDTH-1:0]    wr_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [WIDTH-1:0]    rd_data,
   output logic                ram_we,
   output logic [ADDR_BUS-1:0] ram_addr,
   output logic [WIDTH-1:0]    ram_din,
   input  logic [WIDTH-1:0]    ram_dout,
   output logic                full,
   output logic [ADDR_BUS:0]   fill
);

   localparam logic [ADDR_BUS:0] c_fill_max = (ADDR_BUS+1)'(DEPTH);

   logic [ADDR_BUS-1:0] wr_ptr;
   logic [ADDR_BUS-1:0] rd_ptr;

   logic [ADDR_BUS:0]   fill_q,      fill_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    rd_data_q,   rd_data_d;
   op_t                 last_op_q,   last_op_d;

   logic rd_req;
   logic wr_req;
   logic rd_gnt;
   logic wr_gnt;

   assign full = (fill_q == c_fill_max);

   // rst is folded into the write request so that a producer holding
   // wr_valid during reset cannot reach the RAM write enable.
   assign rd_req = (fill_q != '0) && (!out_valid_q || rd_ready);
   assign wr_req = rst && wr_valid && !full;

   // When both sides request, the side not served last time wins.
   assign wr_gnt = wr_req && (!rd_req || (last_op_q == OP_RD));
   assign rd_gnt = rd_req && (!wr_req || (last_op_q == OP_WR));

   // Independent of wr_valid: a pending read with write-last priority
   // would take the port, so the producer is held off in advance.
   assign wr_ready = rst && !full && !(rd_req && (last_op_q == OP_WR));

   assign ram_we   = wr_gnt;
   assign ram_addr = wr_gnt ? wr_ptr : rd_ptr;
   assign ram_din  = wr_data;

   always_comb begin
      fill_d      = fill_q;
      out_valid_d = out_valid_q;
      rd_data_d   = rd_data_q;
      last_op_d   = last_op_q;

      if (wr_gnt) begin
         fill_d    = fill_q + 1'b1;
         last_op_d = OP_WR;
      end else if (rd_gnt) begin
         fill_d    = fill_q - 1'b1;
         last_op_d = OP_RD;
      end

      if (rd_gnt) begin
         rd_data_d   = ram_dout;
         out_valid_d = 1'b1;
      end else if (out_valid_q && rd_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         rd_data_q   <= '0;
         last_op_q   <= OP_RD;
      end else begin
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         rd_data_q   <= rd_data_d;
         last_op_q   <= last_op_d;
      end
   end

   fifo_ptr #(.ADDR_BUS(ADDR_BUS)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_gnt),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.ADDR_BUS(ADDR_BUS)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_gnt),
      .ptr (rd_ptr)
   );

   assign rd_valid = out_valid_q;
   assign rd_data  = rd_data_q;
   assign fill     = fill_q;

endmodule : sp_ram_fifo_ctrl
`default_nettype wire
